step_ramp_ctrl: RTL

STEP_RAMP_CTRL -- requirements
Module: step_ramp_ctrl

---
 rtl/step_ramp_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/step_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// step_ramp_ctrl
// Move sequencer for a stepper driver. Accepts a move command (step count and
// direction), holds the direction stable for a settle time, then enables the
// step pulse generator while ramping the step period N down from N_MAX to
// N_MIN (ACCEL), holding it (CRUISE) and ramping it back up (DECEL) so that
// the motor is back at N_MAX on the last step. An abort request shortens the
// move to a controlled ramp-down.
//
// Ports
//   clk            system clock, single domain
//   rst            synchronous active-high reset
//   cmd_valid      move command offered
//   cmd_ready      high only in IDLE; command taken when both are high
//   cmd_steps      number of steps to move (0 = empty move, done only)
//   cmd_dir        move direction, latched on the handshake
//   abort          one-cycle request for a controlled stop
//   step_done      one pulse per step emitted by the pulse generator
//   drv_dir        direction to the driver, stable for the whole move
//   drv_enable_SM  enables the pulse generator (ACCEL/CRUISE/DECEL)
//   N              current step period in clk cycles
//   steps_left     remaining steps of the current move
//   busy           high whenever not IDLE
//   done           one-cycle pulse at move completion
// -----------------------------------------------------------------------------
module step_ramp_ctrl #(
  parameter int N_W    = 17,
  parameter int CNT_W  = 24,
  parameter int SETTLE = 500,
  parameter int N_MAX  = 8333,
  parameter int N_MIN  = 1000,
  parameter int N_DEC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             abort,
  input  logic             step_done,
  output logic             drv_dir,
  output logic             drv_enable_SM,
  output logic [N_W-1:0]   N,
  output logic [CNT_W-1:0] steps_left,
  output logic             busy,
  output logic             done
);

  localparam int                SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_W-1:0]    N_MAX_V  = N_W'(N_MAX);
  localparam logic [N_W-1:0]    N_MIN_V  = N_W'(N_MIN);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ACCEL,
    S_CRUISE,
    S_DECEL,
    S_STOP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_W-1:0]     r_n;
  logic [N_W-1:0]     w_n_nxt;
  logic [CNT_W-1:0]   r_steps_left;
  logic [CNT_W-1:0]   w_sl_nxt;
  logic [CNT_W-1:0]   r_ramp_steps;
  logic [CNT_W-1:0]   w_rs_nxt;
  logic               r_dir;
  logic               w_dir_nxt;
  logic [SET_W-1:0]   r_settle_cnt;
  logic [SET_W-1:0]   w_settle_nxt;
  logic               r_zero_done;
  logic               w_zdone_nxt;

  // Period one ramp step faster, clamped at the cruise period.
  function automatic logic [N_W-1:0] f_n_faster(input logic [N_W-1:0] n_in);
    logic [N_W:0] floor_v;
    floor_v = (N_W+1)'(N_MIN) + (N_W+1)'(N_DEC);
    if ({1'b0, n_in} >= floor_v) f_n_faster = n_in - N_W'(N_DEC);
    else                         f_n_faster = N_MIN_V;
  endfunction

  // Period one ramp step slower, clamped at the start/stop period.
  function automatic logic [N_W-1:0] f_n_slower(input logic [N_W-1:0] n_in);
    logic [N_W:0] sum_v;
    sum_v = {1'b0, n_in} + (N_W+1)'(N_DEC);
    if (sum_v >= (N_W+1)'(N_MAX)) f_n_slower = N_MAX_V;
    else                          f_n_slower = sum_v[N_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] f_dec_sat(input logic [CNT_W-1:0] v);
    f_dec_sat = (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] f_inc_sat(input logic [CNT_W-1:0] v);
    f_inc_sat = (v == '1) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] f_min(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b);
    f_min = (a < b) ? a : b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_n          <= N_MAX_V;
      r_steps_left <= '0;
      r_ramp_steps <= '0;
      r_dir        <= 1'b0;
      r_settle_cnt <= '0;
      r_zero_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_n          <= w_n_nxt;
      r_steps_left <= w_sl_nxt;
      r_ramp_steps <= w_rs_nxt;
      r_dir        <= w_dir_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_zero_done  <= w_zdone_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_n_nxt       = r_n;
    w_sl_nxt      = r_steps_left;
    w_rs_nxt      = r_ramp_steps;
    w_dir_nxt     = r_dir;
    w_settle_nxt  = r_settle_cnt;
    w_zdone_nxt   = 1'b0;
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    drv_enable_SM = 1'b0;
    done          = r_zero_done;

    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        w_n_nxt   = N_MAX_V;
        if (cmd_valid) begin
          if (cmd_steps == '0) begin
            // Empty move: acknowledge with done, never enable the driver.
            w_zdone_nxt = 1'b1;
          end else begin
            w_sl_nxt     = cmd_steps;
            w_dir_nxt    = cmd_dir;
            w_rs_nxt     = '0;
            w_settle_nxt = '0;
            w_state_nxt  = S_SETTLE;
          end
        end
      end

      S_SETTLE: begin
        if (abort)                          w_state_nxt  = S_STOP;
        else if (r_settle_cnt == SET_LAST)  w_state_nxt  = S_ACCEL;
        else                                w_settle_nxt = r_settle_cnt + SET_W'(1);
      end

      S_ACCEL: begin
        drv_enable_SM = 1'b1;
        if (step_done) begin
          w_sl_nxt = f_dec_sat(r_steps_left);
          w_rs_nxt = f_inc_sat(r_ramp_steps);
          w_n_nxt  = f_n_faster(r_n);
          // Ramp-down must start once the remaining steps only cover it.
          if (w_sl_nxt <= w_rs_nxt)     w_state_nxt = S_DECEL;
          else if (w_n_nxt == N_MIN_V)  w_state_nxt = S_CRUISE;
        end
        // Abort sees the values already updated by a coincident step.
        if (abort) begin
          w_sl_nxt    = f_min(w_sl_nxt, w_rs_nxt);
          w_state_nxt = S_DECEL;
        end
        // Nothing left to ramp down: finish without an idle DECEL cycle.
        if ((w_state_nxt == S_DECEL) && (w_sl_nxt == '0)) w_state_nxt = S_STOP;
      end

      S_CRUISE: begin
        drv_enable_SM = 1'b1;
        if (step_done) begin
          w_sl_nxt = f_dec_sat(r_steps_left);
          if (w_sl_nxt <= r_ramp_steps) w_state_nxt = S_DECEL;
        end
        if (abort) begin
          w_sl_nxt    = f_min(w_sl_nxt, w_rs_nxt);
          w_state_nxt = S_DECEL;
        end
        if ((w_state_nxt == S_DECEL) && (w_sl_nxt == '0)) w_state_nxt = S_STOP;
      end

      S_DECEL: begin
        drv_enable_SM = 1'b1;
        if (step_done) begin
          w_sl_nxt = f_dec_sat(r_steps_left);
          w_rs_nxt = f_dec_sat(r_ramp_steps);
          w_n_nxt  = f_n_slower(r_n);
          if (w_sl_nxt == '0) w_state_nxt = S_STOP;
        end
      end

      S_STOP: begin
        done        = 1'b1;
        w_n_nxt     = N_MAX_V;
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign drv_dir    = r_dir;
  assign N          = r_n;
  assign steps_left = r_steps_left;

endmodule
